// File: rtl/sap1_ctrl_pkg.sv
// SAP-1 control sequencer shared definitions: opcodes, sequencer states,
// control-bit positions and the control words built from them.
// Control word layout (bit 11..0): {Cp,Ep,nLm,nCE,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo}.
package sap1_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    T5   = 3'd5,
    T6   = 3'd6,
    HALT = 3'd7
  } state_e;

  // Control bit positions
  localparam int unsigned CB_CP  = 11;
  localparam int unsigned CB_EP  = 10;
  localparam int unsigned CB_NLM = 9;
  localparam int unsigned CB_NCE = 8;
  localparam int unsigned CB_NLI = 7;
  localparam int unsigned CB_NEI = 6;
  localparam int unsigned CB_NLA = 5;
  localparam int unsigned CB_EA  = 4;
  localparam int unsigned CB_SU  = 3;
  localparam int unsigned CB_EU  = 2;
  localparam int unsigned CB_NLB = 1;
  localparam int unsigned CB_NLO = 0;

  // Quiescent word: no bus drivers, every active-low load deasserted.
  localparam logic [11:0] CW_IDLE = 12'h3E3;

  // Every other word is the idle word with the relevant bits flipped
  // (active-high enables set, active-low loads/enables cleared).
  localparam logic [11:0] CW_FETCH1   = CW_IDLE ^ (12'h001 << CB_EP)  ^ (12'h001 << CB_NLM);
  localparam logic [11:0] CW_FETCH2   = CW_IDLE ^ (12'h001 << CB_CP);
  localparam logic [11:0] CW_FETCH3   = CW_IDLE ^ (12'h001 << CB_NCE) ^ (12'h001 << CB_NLI);
  localparam logic [11:0] CW_MEM_ADDR = CW_IDLE ^ (12'h001 << CB_NLM) ^ (12'h001 << CB_NEI);
  localparam logic [11:0] CW_LDA_LOAD = CW_IDLE ^ (12'h001 << CB_NCE) ^ (12'h001 << CB_NLA);
  localparam logic [11:0] CW_LOAD_B   = CW_IDLE ^ (12'h001 << CB_NCE) ^ (12'h001 << CB_NLB);
  localparam logic [11:0] CW_ADD      = CW_IDLE ^ (12'h001 << CB_NLA) ^ (12'h001 << CB_EU);
  localparam logic [11:0] CW_SUB      = CW_ADD  ^ (12'h001 << CB_SU);
  localparam logic [11:0] CW_OUT      = CW_IDLE ^ (12'h001 << CB_EA)  ^ (12'h001 << CB_NLO);

  // Map the halt flag and the one-hot ring value onto a sequencer state.
  function automatic state_e t_to_state(input logic halted, input logic [5:0] t);
    state_e st;
    if (halted) begin
      st = HALT;
    end else begin
      case (t)
        6'b000001: st = T1;
        6'b000010: st = T2;
        6'b000100: st = T3;
        6'b001000: st = T4;
        6'b010000: st = T5;
        6'b100000: st = T6;
        default:   st = IDLE;
      endcase
    end
    return st;
  endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// One-hot T-state ring (bit0 = T1). All-zero means "not in a T-state".
// advance_i from all-zero enters T1; from T6 it wraps to T1. clear_i wins.
module sap1_ring_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance_i,
  input  logic       clear_i,
  output logic [5:0] t_o
);

  logic [5:0] t_q;
  logic [5:0] t_d;

  // Next ring value: clear, enter T1, rotate, or hold
  always_comb begin
    t_d = t_q;
    if (clear_i) begin
      t_d = 6'b000000;
    end else if (advance_i) begin
      if (t_q == 6'b000000) begin
        t_d = 6'b000001;
      end else begin
        t_d = {t_q[4:0], t_q[5]};
      end
    end else begin
      t_d = t_q;
    end
  end

  // Ring state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q <= 6'b000000;
    end else begin
      t_q <= t_d;
    end
  end

  assign t_o = t_q;

endmodule

// File: rtl/sap1_control_sequencer.sv
// SAP-1 control sequencer: six T-state fetch/execute cycle, opcode decode
// into the 12-bit control word, run/halt handling and instruction counter.
// Optional build macro SAP1_SINGLE_STEP_EN: T-states advance only on a
// rising edge of step; without it step is ignored.
import sap1_ctrl_pkg::*;

module sap1_control_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        step,
  input  logic [3:0]  opcode,
  output logic [11:0] controlbus,
  output logic [5:0]  t_state,
  output logic        halted,
  output logic [7:0]  instr_count
);

  logic [5:0] t_s;
  logic       halted_q;
  logic       halted_d;
  logic [7:0] instr_count_q;
  logic [7:0] instr_count_d;
  logic       advance_s;
  logic       clear_s;
  logic       step_ok_s;
  state_e     state_s;

`ifdef SAP1_SINGLE_STEP_EN
  logic step_prev_q;

  // Previous step level, so only a 0->1 transition advances the sequence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_prev_q <= 1'b0;
    end else begin
      step_prev_q <= step;
    end
  end

  assign step_ok_s = step & ~step_prev_q;
`else
  logic step_unused_s;
  assign step_unused_s = step;
  assign step_ok_s     = 1'b1;
`endif

  sap1_ring_counter u_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance_i (advance_s),
    .clear_i   (clear_s),
    .t_o       (t_s)
  );

  assign state_s = t_to_state(halted_q, t_s);

  // Sequencing: when the ring moves, when HLT stops it, when an instruction completes
  always_comb begin
    advance_s     = 1'b0;
    clear_s       = 1'b0;
    halted_d      = halted_q;
    instr_count_d = instr_count_q;
    case (state_s)
      IDLE: advance_s = run;
      T1, T2, T3, T5: advance_s = step_ok_s;
      T4: begin
        if (step_ok_s) begin
          if (opcode == OP_HLT) begin
            clear_s  = 1'b1;
            halted_d = 1'b1;
          end else begin
            advance_s = 1'b1;
          end
        end else begin
          advance_s = 1'b0;
        end
      end
      T6: begin
        advance_s = step_ok_s;
        if (step_ok_s && (instr_count_q != 8'hFF)) begin
          instr_count_d = instr_count_q + 8'd1;
        end else begin
          instr_count_d = instr_count_q;
        end
      end
      HALT: advance_s = 1'b0;
      default: advance_s = 1'b0;
    endcase
  end

  // Halt flag and saturating instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q      <= 1'b0;
      instr_count_q <= 8'd0;
    end else begin
      halted_q      <= halted_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Control word decode from the registered state; opcode matters only in T4..T6
  always_comb begin
    controlbus = CW_IDLE;
    case (state_s)
      T1: controlbus = CW_FETCH1;
      T2: controlbus = CW_FETCH2;
      T3: controlbus = CW_FETCH3;
      T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: controlbus = CW_MEM_ADDR;
          OP_OUT:                 controlbus = CW_OUT;
          default:                controlbus = CW_IDLE;
        endcase
      end
      T5: begin
        case (opcode)
          OP_LDA:         controlbus = CW_LDA_LOAD;
          OP_ADD, OP_SUB: controlbus = CW_LOAD_B;
          default:        controlbus = CW_IDLE;
        endcase
      end
      T6: begin
        case (opcode)
          OP_ADD:  controlbus = CW_ADD;
          OP_SUB:  controlbus = CW_SUB;
          default: controlbus = CW_IDLE;
        endcase
      end
      default: controlbus = CW_IDLE;
    endcase
  end

  assign t_state     = t_s;
  assign halted      = halted_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_sap1_control_sequencer.sv
// Self-checking bench for sap1_control_sequencer: directed scenarios with
// literal expectations plus randomized stimulus against a phase-level model.
module tb_sap1_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        step;
  logic [3:0]  opcode;
  logic [11:0] controlbus;
  logic [5:0]  t_state;
  logic        halted;
  logic [7:0]  instr_count;
  logic [26:0] obs;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: phase 0 = idle, 1..6 = T1..T6, 7 = halted
  int m_ph;
  int m_cnt;
  bit m_prev;

  sap1_control_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .step        (step),
    .opcode      (opcode),
    .controlbus  (controlbus),
    .t_state     (t_state),
    .halted      (halted),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  assign obs = {controlbus, t_state, halted, instr_count};

  function automatic logic [11:0] ref_cw(input int ph, input logic [3:0] op);
    logic [11:0] w;
    w = 12'h3E3;
    case (ph)
      1: w = 12'h5E3;
      2: w = 12'hBE3;
      3: w = 12'h263;
      4: w = (op == 4'h0 || op == 4'h1 || op == 4'h2) ? 12'h1A3 : (op == 4'hE ? 12'h3F2 : 12'h3E3);
      5: w = (op == 4'h0) ? 12'h2C3 : ((op == 4'h1 || op == 4'h2) ? 12'h2E1 : 12'h3E3);
      6: w = (op == 4'h1) ? 12'h3C7 : (op == 4'h2 ? 12'h3CF : 12'h3E3);
      default: w = 12'h3E3;
    endcase
    return w;
  endfunction

  function automatic logic [26:0] ref_obs();
    logic [5:0] ts;
    ts = (m_ph >= 1 && m_ph <= 6) ? 6'(1 << (m_ph - 1)) : 6'd0;
    return {ref_cw(m_ph, opcode), ts, (m_ph == 7), 8'(m_cnt)};
  endfunction

  // One clock: model consumes the inputs seen at the edge, then settle
  task automatic tick();
    bit adv;
    @(posedge clk);
`ifdef SAP1_SINGLE_STEP_EN
    adv    = step && !m_prev;
    m_prev = step;
`else
    adv = 1'b1;
`endif
    if (m_ph == 0) begin
      if (run) m_ph = 1;
    end else if (m_ph >= 1 && m_ph <= 6 && adv) begin
      if (m_ph == 4 && opcode == 4'hF) m_ph = 7;
      else if (m_ph == 6) begin
        m_ph = 1;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end else m_ph = m_ph + 1;
    end
    #1;
  endtask

  // Advance one T-state (supplies a step edge in single-step builds)
  task automatic go();
`ifdef SAP1_SINGLE_STEP_EN
    step = 1'b0;
    tick();
    step = 1'b1;
`endif
    tick();
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    run    = 1'b0;
    step   = 1'b0;
    opcode = 4'h0;
    m_ph   = 0;
    m_cnt  = 0;
    m_prev = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests_run++;
    if (obs !== {12'h3E3, 6'd0, 1'b0, 8'd0}) begin
      tests_failed++;
      $display("FAIL reset_state: got %h expected %h", obs, {12'h3E3, 6'd0, 1'b0, 8'd0});
    end
    run = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (obs !== {12'h3E3, 6'd0, 1'b0, 8'd0}) begin
      tests_failed++;
      $display("FAIL idle_hold: got %h expected %h", obs, {12'h3E3, 6'd0, 1'b0, 8'd0});
    end
  endtask

  task automatic test_lda_sequence();
    logic [11:0] cw_exp [8] = '{12'h3E3, 12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2C3, 12'h3E3, 12'h5E3};
    logic [26:0] e;
    do_reset();
    opcode = 4'h0;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        run = 1'b1;
        tick();
        run = 1'b0;
      end else if (i > 1) begin
        go();
      end
      e = {cw_exp[i], (i == 0) ? 6'd0 : (i == 7 ? 6'd1 : 6'(1 << (i - 1))), 1'b0, (i == 7) ? 8'd1 : 8'd0};
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL lda_seq[%0d]: got %h expected %h", i, obs, e);
      end
    end
  endtask

  task automatic test_add_sub();
    logic [3:0]  ops   [2] = '{4'h2, 4'h1};
    logic [11:0] t6_cw [2] = '{12'h3CF, 12'h3C7};
    logic [11:0] seq   [6];
    for (int k = 0; k < 2; k++) begin
      seq = '{12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2E1, t6_cw[k]};
      do_reset();
      run = 1'b1;
      tick();
      run = 1'b0;
      for (int i = 0; i < 6; i++) begin
        if (i > 0) go();
        // opcode is garbage during fetch, settled before T4
        opcode = (i < 3) ? 4'($urandom_range(0, 15)) : ops[k];
        if (i == 2) begin
          tests_run++;
          if (controlbus !== 12'h263) begin
            tests_failed++;
            $display("FAIL fetch_opcode_indep: got %h expected %h", controlbus, 12'h263);
          end
          opcode = ops[k];
        end
        tests_run++;
        if (controlbus !== seq[i] || t_state !== 6'(1 << i)) begin
          tests_failed++;
          $display("FAIL arith_op%0h_T%0d: got cb=%h t=%b expected cb=%h t=%b",
                   ops[k], i + 1, controlbus, t_state, seq[i], 6'(1 << i));
        end
      end
    end
  endtask

  task automatic test_nop();
    do_reset();
    opcode = 4'h7;
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (3) go();
    for (int i = 4; i <= 6; i++) begin
      tests_run++;
      if (controlbus !== 12'h3E3 || t_state !== 6'(1 << (i - 1))) begin
        tests_failed++;
        $display("FAIL nop_T%0d: got cb=%h t=%b expected cb=3e3", i, controlbus, t_state);
      end
      go();
    end
    tests_run++;
    if (instr_count !== 8'd1 || t_state !== 6'b000001) begin
      tests_failed++;
      $display("FAIL nop_count: got cnt=%0d t=%b expected cnt=1 t=000001", instr_count, t_state);
    end
  endtask

  task automatic test_halt();
    do_reset();
    opcode = 4'hF;
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (3) go();
    tests_run++;
    if (obs !== {12'h3E3, 6'b001000, 1'b0, 8'd0}) begin
      tests_failed++;
      $display("FAIL hlt_T4: got %h expected %h", obs, {12'h3E3, 6'b001000, 1'b0, 8'd0});
    end
    go();
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (obs !== {12'h3E3, 6'd0, 1'b1, 8'd0}) begin
        tests_failed++;
        $display("FAIL halt_hold[%0d]: got %h expected %h", i, obs, {12'h3E3, 6'd0, 1'b1, 8'd0});
      end
      run  = 1'b1;
      step = ~step;
      tick();
      run = 1'b0;
    end
  endtask

  task automatic test_reset_mid_instr();
    do_reset();
    opcode = 4'h1;
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (6) go();
    repeat (4) go();
    tests_run++;
    if (obs !== {12'h2E1, 6'b010000, 1'b0, 8'd1}) begin
      tests_failed++;
      $display("FAIL add_T5_before_reset: got %h expected %h", obs, {12'h2E1, 6'b010000, 1'b0, 8'd1});
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (obs !== {12'h3E3, 6'd0, 1'b0, 8'd0}) begin
      tests_failed++;
      $display("FAIL async_reset: got %h expected %h", obs, {12'h3E3, 6'd0, 1'b0, 8'd0});
    end
    m_ph  = 0;
    m_cnt = 0;
    m_prev = 1'b0;
    step  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    do_reset();
    opcode = 4'h7;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 260 * 6; i++) begin
      go();
      tests_run++;
      if (obs !== ref_obs()) begin
        tests_failed++;
        $display("FAIL sat_cycle[%0d]: got %h expected %h", i, obs, ref_obs());
      end
    end
    tests_run++;
    if (instr_count !== 8'hFF) begin
      tests_failed++;
      $display("FAIL saturate: got %h expected ff", instr_count);
    end
  endtask

  task automatic test_random();
    int stuck;
    do_reset();
    stuck = 0;
    for (int i = 0; i < 800; i++) begin
      run    = ($urandom_range(0, 3) == 0);
      step   = 1'($urandom_range(0, 1));
      opcode = 4'($urandom_range(0, 15));
      tick();
      tests_run++;
      if (obs !== ref_obs()) begin
        tests_failed++;
        $display("FAIL random[%0d]: got %h expected %h", i, obs, ref_obs());
      end
      stuck = (m_ph == 7) ? stuck + 1 : 0;
      if (stuck > 4) begin
        do_reset();
        stuck = 0;
      end
    end
  endtask

`ifdef SAP1_SINGLE_STEP_EN
  task automatic test_single_step();
    do_reset();
    opcode = 4'h0;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if (controlbus !== 12'h5E3 || t_state !== 6'b000001) begin
        tests_failed++;
        $display("FAIL step_wait[%0d]: got cb=%h t=%b expected cb=5e3 t=000001", i, controlbus, t_state);
      end
    end
    for (int k = 1; k < 6; k++) begin
      step = 1'b1;
      tick();
      tests_run++;
      if (t_state !== 6'(1 << k)) begin
        tests_failed++;
        $display("FAIL step_edge[%0d]: got t=%b expected t=%b", k, t_state, 6'(1 << k));
      end
      tick();
      tests_run++;
      if (t_state !== 6'(1 << k)) begin
        tests_failed++;
        $display("FAIL step_high_hold[%0d]: got t=%b expected t=%b", k, t_state, 6'(1 << k));
      end
      step = 1'b0;
      tick();
    end
  endtask
`endif

  initial begin
    rst_n  = 1'b0;
    run    = 1'b0;
    step   = 1'b0;
    opcode = 4'h0;
    test_reset();
    test_lda_sequence();
    test_add_sub();
    test_nop();
    test_halt();
    test_reset_mid_instr();
    test_saturation();
    test_random();
`ifdef SAP1_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
